// File: rtl/hazard_ctrl.sv
// IF/ID hazard and sequencing controller: load-use / branch-operand stalls, bubbles and redirect flushes.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_stall,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic            id_taken,
  input  logic            ex_memread,
  input  logic            ex_regwrite,
  input  logic [REGW-1:0] ex_rd,
  input  logic            mem_memread,
  input  logic [REGW-1:0] mem_rd,
  output logic            pc_write,
  output logic            ifid_hold,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       ex_hit, mem_hit;
  logic [1:0] need;
  logic       redirect;
  logic       stall_cyc, flush_cyc;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign ex_hit  = (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign mem_hit = (mem_rd != '0) &&
                   ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

  always_comb begin
    need = 2'd0;
    if (ex_memread && ex_hit) begin
      need = id_branch ? 2'd2 : 2'd1;
    end else if (id_branch && ((ex_regwrite && !ex_memread && ex_hit) ||
                               (mem_memread && mem_hit))) begin
      need = 2'd1;
    end
  end

  assign redirect = id_jump || (id_branch && id_taken);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stall_cyc   = 1'b0;
    flush_cyc   = 1'b0;
    pc_write    = 1'b1;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset || ext_stall) begin
      pc_write  = 1'b0;
      ifid_hold = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (need != 2'd0) begin
            stall_cyc = 1'b1;
            if (need == 2'd2) begin
              state_d = STALL;
              rem_d   = 2'd1;
            end
          end else if (redirect) begin
            flush_cyc = 1'b1;
          end
        end
        STALL: begin
          // Operands are still in flight here, so hazard inputs and id_taken are ignored.
          stall_cyc = 1'b1;
          rem_d     = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 2'd0;
        end
      endcase
      if (stall_cyc) begin
        pc_write    = 1'b0;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
      if (flush_cyc) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNTW-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_cyc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      end
      if (flush_cyc && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNTW'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
